// File: rtl/spi_cs_sequencer.sv
// Chip-select sequencer for a single-byte SPI engine: holds CS_n low across a multi-byte
// transaction, forwards bytes with zero latency and enforces a minimum CS_n high time.
module spi_cs_sequencer #(
    parameter int MAX_BYTES        = 2,
    parameter int CS_INACTIVE_CLKS = 1,
    localparam int CW              = $clog2(MAX_BYTES + 1)
) (
    input  logic          i_Clk,
    input  logic          i_Rst,

    input  logic [CW-1:0] i_TX_Count,
    input  logic [7:0]    i_TX_Byte,
    input  logic          i_TX_DV,
    output logic          o_TX_Ready,

    output logic [CW-1:0] o_RX_Count,
    output logic          o_RX_DV,
    output logic [7:0]    o_RX_Byte,

    output logic          o_SPI_CS_n,

    output logic          o_Byte_TX_DV,
    output logic [7:0]    o_Byte_TX_Byte,
    input  logic          i_Byte_TX_Ready,
    input  logic          i_Byte_RX_DV,
    input  logic [7:0]    i_Byte_RX_Byte
);

    localparam int ICW = (CS_INACTIVE_CLKS > 1) ? $clog2(CS_INACTIVE_CLKS) : 1;
    localparam logic [CW-1:0]  MaxCount     = CW'(MAX_BYTES);
    localparam logic [ICW-1:0] InactiveLoad = ICW'(CS_INACTIVE_CLKS - 1);

    typedef enum logic [1:0] {
        StIdle,
        StTransfer,
        StCsInactive
    } state_e;

    state_e         state;
    logic [CW-1:0]  remaining;
    logic [ICW-1:0] inactive_cnt;
    logic [CW-1:0]  start_remaining;
    logic           tx_accept;

    always_comb begin
        o_TX_Ready = 1'b0;
        unique case (state)
            StIdle:       o_TX_Ready = 1'b1;
            StTransfer:   o_TX_Ready = i_Byte_TX_Ready && (remaining != '0);
            StCsInactive: o_TX_Ready = 1'b0;
            default:      o_TX_Ready = 1'b0;
        endcase
    end

    assign tx_accept      = i_TX_DV & o_TX_Ready;
    assign o_Byte_TX_DV   = tx_accept;
    assign o_Byte_TX_Byte = i_TX_Byte;

    // A count of zero is treated as one byte; oversize counts clamp to MAX_BYTES.
    always_comb begin
        if (i_TX_Count == '0) begin
            start_remaining = '0;
        end else if (i_TX_Count > MaxCount) begin
            start_remaining = MaxCount - 1'b1;
        end else begin
            start_remaining = i_TX_Count - 1'b1;
        end
    end

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            state        <= StIdle;
            o_SPI_CS_n   <= 1'b1;
            remaining    <= '0;
            inactive_cnt <= '0;
            o_RX_Count   <= '0;
        end else begin
            if (o_RX_DV) begin
                o_RX_Count <= o_RX_Count + 1'b1;
            end
            unique case (state)
                StIdle: begin
                    if (tx_accept) begin
                        remaining  <= start_remaining;
                        o_SPI_CS_n <= 1'b0;
                        o_RX_Count <= '0;
                        state      <= StTransfer;
                    end
                end
                StTransfer: begin
                    if (tx_accept) begin
                        remaining <= remaining - 1'b1;
                    end else if ((remaining == '0) && i_Byte_TX_Ready) begin
                        // Last byte has left the engine: release CS and start the gap.
                        o_SPI_CS_n   <= 1'b1;
                        inactive_cnt <= InactiveLoad;
                        state        <= StCsInactive;
                    end
                end
                StCsInactive: begin
                    if (inactive_cnt == '0) begin
                        state <= StIdle;
                    end else begin
                        inactive_cnt <= inactive_cnt - 1'b1;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            o_RX_DV   <= 1'b0;
            o_RX_Byte <= 8'h00;
        end else begin
            o_RX_DV   <= i_Byte_RX_DV;
            o_RX_Byte <= i_Byte_RX_Byte;
        end
    end

endmodule
